// File: rtl/dadda_final_adder.sv
// Two-stage pipelined carry-propagate adder closing a Dadda tree.
// Ports: clk, rst, in_valid/in_ready, vector0/1, out_valid/out_ready,
//        out_sum (Width+1), done_count (16, wraps).
module dadda_final_adder #(
  parameter int Width      = 12,
  parameter int SplitWidth = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] vector0,
  input  logic [Width-1:0] vector1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width:0]   out_sum,
  output logic [15:0]      done_count
);

  localparam int HiW = Width - SplitWidth;

  logic              s1_valid_q, s1_valid_d;
  logic [SplitWidth:0] s1_lo_q, s1_lo_d;
  logic [HiW-1:0]    s1_hi0_q, s1_hi0_d;
  logic [HiW-1:0]    s1_hi1_q, s1_hi1_d;
  logic              out_valid_q, out_valid_d;
  logic [Width:0]    out_sum_q, out_sum_d;
  logic [15:0]       done_count_q, done_count_d;

  logic              accept;
  logic              done;
  logic              s2_load;
  logic [HiW:0]      hi_sum;

  // Empty S2 is refilled regardless of out_ready (bubble collapse).
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign done     = out_valid_q && out_ready;

  // Upper half plus the mid carry from the stage-1 low add.
  assign hi_sum = {1'b0, s1_hi0_q}
                + {1'b0, s1_hi1_q}
                + {{HiW{1'b0}}, s1_lo_q[SplitWidth]};

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_lo_d      = s1_lo_q;
    s1_hi0_d     = s1_hi0_q;
    s1_hi1_d     = s1_hi1_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    done_count_d = done_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = {1'b0, vector0[SplitWidth-1:0]}
                 + {1'b0, vector1[SplitWidth-1:0]};
      s1_hi0_d   = vector0[Width-1:SplitWidth];
      s1_hi1_d   = vector1[Width-1:SplitWidth];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      out_sum_d   = {hi_sum, s1_lo_q[SplitWidth-1:0]};
    end else if (done) begin
      out_valid_d = 1'b0;
    end

    if (done) begin
      done_count_d = done_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_lo_q      <= '0;
      s1_hi0_q     <= '0;
      s1_hi1_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      done_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_q      <= s1_lo_d;
      s1_hi0_q     <= s1_hi0_d;
      s1_hi1_q     <= s1_hi1_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      done_count_q <= done_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign done_count = done_count_q;

endmodule
